// File: rtl/tk1_spi_defs.sv
// Constants shared between the tk1 SPI responder and initiator: controller
// state encodings and the SPI mode 0 clock polarity/phase.
package tk1_spi_defs;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_SHIFT = 1'b1
    } ctrl_state_e;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int unsigned SPI_BYTE_BITS = 8;

endpackage

// File: rtl/tk1_spi_sync.sv
// N-stage flip-flop synchronizer for a single asynchronous bit, with a
// configurable reset value.
module tk1_spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tk1_spi_slave.sv
// SPI mode 0 responder: oversamples the SPI pins on clk, exchanges one byte
// per 8 SCK cycles MSB first, with a single-entry transmit holding register.
module tk1_spi_slave
    import tk1_spi_defs::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_ss,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_data_vld,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    output logic       tx_underrun,
    output logic       selected
);

    logic ss_sync, sck_sync, mosi_sync;

    tk1_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_ss),
        .q_o     (ss_sync)
    );

    tk1_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_sck),
        .q_o     (sck_sync)
    );

    tk1_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_mosi),
        .q_o     (mosi_sync)
    );

    ctrl_state_e state_q;
    logic        sck_prev_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_shift_q;
    logic [7:0]  tx_shift_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic        oe_q;
    logic        sel_q;
    logic [7:0]  rx_data_q;
    logic        rx_vld_q;
    logic        underrun_q;

    logic sck_rise, sck_fall, load_req;

    assign sck_rise = sck_sync & ~sck_prev_q;
    assign sck_fall = ~sck_sync & sck_prev_q;

    // Fresh byte needed on select, and on the falling edge closing each byte.
    always_comb begin
        load_req = 1'b0;
        if (!ss_sync) begin
            if (state_q == CTRL_IDLE) begin
                load_req = 1'b1;
            end else if (sck_fall && (bit_cnt_q == 3'd0)) begin
                load_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CTRL_IDLE;
            sck_prev_q  <= SPI_CPOL;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            oe_q        <= 1'b0;
            sel_q       <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_vld_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_prev_q <= sck_sync;
            rx_vld_q   <= 1'b0;
            underrun_q <= 1'b0;

            if (tx_data_vld && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            // An underrun load leaves a same-cycle write in the holding register.
            if (load_req) begin
                if (hold_full_q) begin
                    tx_shift_q  <= hold_q;
                    hold_full_q <= 1'b0;
                end else begin
                    tx_shift_q <= IDLE_BYTE;
                    underrun_q <= 1'b1;
                end
            end

            case (state_q)
                CTRL_IDLE: begin
                    oe_q  <= 1'b0;
                    sel_q <= 1'b0;
                    if (!ss_sync) begin
                        state_q   <= CTRL_SHIFT;
                        bit_cnt_q <= 3'd0;
                        oe_q      <= 1'b1;
                        sel_q     <= 1'b1;
                    end
                end
                CTRL_SHIFT: begin
                    if (ss_sync) begin
                        state_q   <= CTRL_IDLE;
                        bit_cnt_q <= 3'd0;
                        oe_q      <= 1'b0;
                        sel_q     <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            rx_shift_q <= {rx_shift_q[6:0], mosi_sync};
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q <= {rx_shift_q[6:0], mosi_sync};
                                rx_vld_q  <= 1'b1;
                            end
                        end
                        if (sck_fall && (bit_cnt_q != 3'd0)) begin
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= CTRL_IDLE;
            endcase
        end
    end

    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_data_vld = rx_vld_q;
    assign tx_underrun = underrun_q;
    assign selected    = sel_q;

endmodule
